// File: rtl/eth_rx_decap_if.sv
// Interface between the MAC RX stream, the decapsulator and the CDC FIFO
// write port. The slave side is the decapsulator; the master side feeds the
// RX beats and the FIFO prog_full flag and observes the FIFO writes.
interface eth_rx_decap_if;
  logic        s_axis_tvalid;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        wr_en;
  logic [73:0] din;
  logic        full;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, full,
    output wr_en, din
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, full,
    input  wr_en, din
  );
endinterface

// File: rtl/eth_rx_decap.sv
// Receive-side decapsulator: filters frames by destination MAC and EtherType,
// strips the 16-byte header and writes payload beats into the CDC FIFO tagged
// {err, eof, keep, data}. The MAC cannot be stalled, so a FIFO that fills up
// mid-frame truncates the frame and a terminator word closes it later.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  HDR0    | expecting beat 0: dst MAC + first two src bytes
//  HDR1    | expecting beat 1: rest of src, EtherType, sequence number
//  PAYLOAD | accepted frame, payload beats go to the FIFO
//  DISCARD | rest of the current frame is dropped
module eth_rx_decap #(
  parameter logic [47:0] MAC_ADDR     = 48'h00_0A_35_00_00_01,
  parameter logic [15:0] ETHERTYPE    = 16'h88B5,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter int          CNT_WIDTH    = 32
) (
  input  logic                 clk156,
  input  logic                 sys_rst,
  eth_rx_decap_if.slave        bus,
  output logic [CNT_WIDTH-1:0] cnt_good,
  output logic [CNT_WIDTH-1:0] cnt_drop,
  output logic [CNT_WIDTH-1:0] cnt_fcs,
  output logic [CNT_WIDTH-1:0] cnt_seq_gap,
  output logic [15:0]          last_seq
);

  typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD, DISCARD} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [73:0]          TERM_WORD = {1'b1, 1'b1, 8'h00, 64'h0};

  state_t      state;
  logic        seq_valid;
  logic        term_pending;

  logic [47:0] rx_dst;
  logic [15:0] rx_type;
  logic [15:0] rx_seq;
  logic        dst_ok;
  logic        payload_wr;

  // Header fields are carried MSB-first in byte order, so reassemble them
  // from the little-endian lane layout of the stream.
  always_comb begin
    rx_dst     = {bus.s_axis_tdata[7:0],   bus.s_axis_tdata[15:8],
                  bus.s_axis_tdata[23:16], bus.s_axis_tdata[31:24],
                  bus.s_axis_tdata[39:32], bus.s_axis_tdata[47:40]};
    rx_type    = {bus.s_axis_tdata[39:32], bus.s_axis_tdata[47:40]};
    rx_seq     = {bus.s_axis_tdata[55:48], bus.s_axis_tdata[63:56]};
    dst_ok     = (rx_dst == MAC_ADDR) || (ACCEPT_BCAST && (rx_dst == 48'hFFFF_FFFF_FFFF));
    payload_wr = bus.s_axis_tvalid && (state == PAYLOAD) && !bus.full;
  end

  // Frame parser, FIFO write register, statistics and overflow terminator.
  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state        <= HDR0;
      seq_valid    <= 1'b0;
      term_pending <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.din      <= '0;
      cnt_good     <= '0;
      cnt_drop     <= '0;
      cnt_fcs      <= '0;
      cnt_seq_gap  <= '0;
      last_seq     <= '0;
    end else begin
      bus.wr_en <= 1'b0;

      if (bus.s_axis_tvalid) begin
        case (state)
          HDR0: begin
            // A one-beat frame ends here; anything else that fails the
            // filter (or arrives while a terminator is owed) is swallowed.
            if (bus.s_axis_tlast) begin
              cnt_drop <= cnt_drop + CNT_ONE;
            end else if (!dst_ok || term_pending) begin
              cnt_drop <= cnt_drop + CNT_ONE;
              state    <= DISCARD;
            end else begin
              state <= HDR1;
            end
          end

          HDR1: begin
            if (rx_type != ETHERTYPE) begin
              cnt_drop <= cnt_drop + CNT_ONE;
              state    <= bus.s_axis_tlast ? HDR0 : DISCARD;
            end else if (bus.s_axis_tlast) begin
              cnt_drop <= cnt_drop + CNT_ONE;
              state    <= HDR0;
            end else begin
              if (seq_valid && (rx_seq != last_seq + 16'd1))
                cnt_seq_gap <= cnt_seq_gap + CNT_ONE;
              last_seq  <= rx_seq;
              seq_valid <= 1'b1;
              state     <= PAYLOAD;
            end
          end

          PAYLOAD: begin
            if (bus.full) begin
              term_pending <= 1'b1;
              cnt_drop     <= cnt_drop + CNT_ONE;
              state        <= bus.s_axis_tlast ? HDR0 : DISCARD;
            end else begin
              bus.wr_en <= 1'b1;
              bus.din   <= {bus.s_axis_tlast & ~bus.s_axis_tuser,
                            bus.s_axis_tlast,
                            bus.s_axis_tlast ? bus.s_axis_tkeep : 8'hFF,
                            bus.s_axis_tdata};
              if (bus.s_axis_tlast) begin
                if (bus.s_axis_tuser) cnt_good <= cnt_good + CNT_ONE;
                else                  cnt_fcs  <= cnt_fcs + CNT_ONE;
                state <= HDR0;
              end
            end
          end

          DISCARD: begin
            if (bus.s_axis_tlast) state <= HDR0;
          end

          default: state <= HDR0;
        endcase
      end

      // Close a truncated frame as soon as the FIFO has room again so the
      // PCIe side sees an errored end-of-frame instead of a dangling one.
      if (term_pending && !bus.full && !payload_wr) begin
        bus.wr_en    <= 1'b1;
        bus.din      <= TERM_WORD;
        term_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_decap.sv
// Self-checking bench for eth_rx_decap: directed frames followed by random
// traffic, compared against a frame-level reference model.
module tb_eth_rx_decap;
  localparam logic [47:0] MAC   = 48'h00_0A_35_00_00_01;
  localparam logic [15:0] ETYPE = 16'h88B5;
  localparam bit          BCAST = 1'b1;
  localparam logic [73:0] TERM  = {1'b1, 1'b1, 8'h00, 64'h0};
  localparam logic [47:0] BC    = 48'hFFFF_FFFF_FFFF;

  logic        clk156 = 1'b0;
  logic        sys_rst;
  logic [31:0] cnt_good, cnt_drop, cnt_fcs, cnt_seq_gap;
  logic [15:0] last_seq;

  eth_rx_decap_if bus ();

  eth_rx_decap #(
    .MAC_ADDR(MAC), .ETHERTYPE(ETYPE), .ACCEPT_BCAST(BCAST), .CNT_WIDTH(32)
  ) dut (
    .clk156(clk156), .sys_rst(sys_rst), .bus(bus),
    .cnt_good(cnt_good), .cnt_drop(cnt_drop), .cnt_fcs(cnt_fcs),
    .cnt_seq_gap(cnt_seq_gap), .last_seq(last_seq)
  );

  always #5 clk156 = ~clk156;

  int          n_chk = 0;
  int          n_err = 0;
  logic [73:0] act_q[$];
  logic [73:0] exp_q[$];

  // reference model state
  logic [31:0] m_good, m_drop, m_fcs, m_gap;
  logic [15:0] m_last_seq;
  bit          m_seq_valid, m_pending;
  int          full_pct = 0, gap_pct = 0, force_cnt = 0;

  always @(negedge clk156) if (bus.wr_en === 1'b1) act_q.push_back(bus.din);

  task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_beat0(input logic [47:0] dst, input logic [15:0] src);
    logic [63:0] w;
    for (int i = 0; i < 6; i++) w[8*i +: 8] = dst[8*(5-i) +: 8];
    w[55:48] = src[15:8];
    w[63:56] = src[7:0];
    return w;
  endfunction

  function automatic logic [63:0] mk_beat1(input logic [31:0] src, input logic [15:0] et, input logic [15:0] seq);
    return {seq[7:0], seq[15:8], et[7:0], et[15:8], src[7:0], src[15:8], src[23:16], src[31:24]};
  endfunction

  function automatic logic next_full();
    if (force_cnt > 0) begin
      force_cnt--;
      return 1'b1;
    end
    return ($urandom_range(0, 99) < full_pct);
  endfunction

  function automatic void model_reset();
    m_good = 0; m_drop = 0; m_fcs = 0; m_gap = 0;
    m_last_seq = 0; m_seq_valid = 0; m_pending = 0;
  endfunction

  // One clock of input; an owed terminator goes out in the first cycle the
  // FIFO is not full.
  task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic l, input logic u, input logic f);
    @(negedge clk156);
    bus.s_axis_tvalid = v;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = k;
    bus.s_axis_tlast  = l;
    bus.s_axis_tuser  = u;
    bus.full          = f;
    if (m_pending && !f) begin
      exp_q.push_back(TERM);
      m_pending = 0;
    end
  endtask

  task automatic idle();
    drive(1'b0, {$urandom, $urandom}, 8'($urandom), 1'b0, 1'b0, next_full());
  endtask

  // npay < 0 means a single-beat frame; with_last=0 leaves the frame open.
  task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] seq,
                            input int npay, input logic [7:0] lkeep, input logic user,
                            input int force_at, input bit with_last);
    int n;
    bit done, dst_ok, p0;
    logic f, l, u;
    logic [63:0] d;
    logic [7:0] k;
    n = (npay < 0) ? 1 : npay + 2;
    dst_ok = (dst == MAC) || (BCAST && dst == BC);
    done = 0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < gap_pct) idle();
      if (i == force_at) force_cnt = 10;
      f = next_full();
      l = with_last && (i == n - 1);
      k = l ? lkeep : 8'($urandom);
      u = l ? user : 1'($urandom);
      if (i == 0)      d = mk_beat0(dst, 16'($urandom));
      else if (i == 1) d = mk_beat1($urandom, et, seq);
      else             d = {$urandom, $urandom};
      p0 = m_pending;
      drive(1'b1, d, k, l, u, f);
      if (done) continue;
      if (i == 0) begin
        if (l || !dst_ok || p0) begin m_drop++; done = 1; end
      end else if (i == 1) begin
        if (et != ETYPE || l) begin
          m_drop++; done = 1;
        end else begin
          if (m_seq_valid && seq != m_last_seq + 16'd1) m_gap++;
          m_last_seq = seq;
          m_seq_valid = 1;
        end
      end else if (f) begin
        m_pending = 1; m_drop++; done = 1;
      end else begin
        exp_q.push_back({l & ~user, l, l ? lkeep : 8'hFF, d});
        if (l) begin
          if (user) m_good++;
          else      m_fcs++;
        end
      end
    end
  endtask

  task automatic flush();
    int save;
    save = full_pct;
    full_pct = 0;
    repeat (14) idle();
    full_pct = save;
  endtask

  task automatic compare(input string tag);
    chk({tag, "_nwr"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      chk({tag, "_din"}, act_q[i], exp_q[i]);
    chk({tag, "_good"}, cnt_good, m_good);
    chk({tag, "_drop"}, cnt_drop, m_drop);
    chk({tag, "_fcs"}, cnt_fcs, m_fcs);
    chk({tag, "_gap"}, cnt_seq_gap, m_gap);
    chk({tag, "_lseq"}, last_seq, m_last_seq);
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rseq;
    logic [47:0] dst;
    logic [15:0] et;
    int r;

    sys_rst = 1'b1;
    bus.s_axis_tvalid = 0; bus.s_axis_tdata = 0; bus.s_axis_tkeep = 0;
    bus.s_axis_tlast = 0; bus.s_axis_tuser = 0; bus.full = 0;
    model_reset();
    repeat (3) @(negedge clk156);
    sys_rst = 1'b0;
    @(negedge clk156);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_din", bus.din, 0);
    chk("rst_good", cnt_good, 0);
    chk("rst_drop", cnt_drop, 0);
    chk("rst_fcs", cnt_fcs, 0);
    chk("rst_gap", cnt_seq_gap, 0);
    chk("rst_lseq", last_seq, 0);

    // good frame, 3 payload beats, short last beat
    send_frame(MAC, ETYPE, 16'd0, 3, 8'h0F, 1'b1, -1, 1);
    flush();
    chk("t1_tail", (act_q.size() > 2) ? act_q[2][73:64] : 10'h3FF, {1'b0, 1'b1, 8'h0F});
    chk("t1_good", cnt_good, 1);
    compare("t1");

    // wrong EtherType
    send_frame(MAC, 16'h0800, 16'd1, 3, 8'hFF, 1'b1, -1, 1);
    flush();
    chk("t2_nwr", act_q.size(), 0);
    chk("t2_drop", cnt_drop, 1);
    compare("t2");

    // bad FCS
    send_frame(MAC, ETYPE, 16'd1, 2, 8'hFF, 1'b0, -1, 1);
    flush();
    chk("t3_tailflags", (act_q.size() > 1) ? act_q[1][73:72] : 2'b00, 2'b11);
    chk("t3_fcs", cnt_fcs, 1);
    compare("t3");

    // overflow on payload beat 3, then a frame arriving while full
    send_frame(MAC, ETYPE, 16'd2, 5, 8'hFF, 1'b1, 4, 1);
    send_frame(MAC, ETYPE, 16'd3, 2, 8'hFF, 1'b1, -1, 1);
    flush();
    chk("t4_nwr3", act_q.size(), 3);
    chk("t4_term", (act_q.size() > 2) ? act_q[2] : 74'h0, TERM);
    chk("t4_drop", cnt_drop, 3);
    compare("t4");

    // runt, then broadcast destination
    send_frame(MAC, ETYPE, 16'd3, 0, 8'hFF, 1'b1, -1, 1);
    flush();
    chk("t5_runt_drop", cnt_drop, 4);
    send_frame(BC, ETYPE, 16'd3, 1, 8'h01, 1'b1, -1, 1);
    flush();
    chk("t5_bcast_good", cnt_good, BCAST ? 2 : 1);
    compare("t5");

    // reset in the middle of a payload
    send_frame(MAC, ETYPE, 16'h1234, 3, 8'hFF, 1'b1, -1, 0);
    @(negedge clk156);
    sys_rst = 1'b1;
    bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = {$urandom, $urandom}; bus.s_axis_tlast = 1'b0;
    @(negedge clk156);
    sys_rst = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    chk("mrst_wr_en", bus.wr_en, 0);
    chk("mrst_good", cnt_good, 0);
    chk("mrst_drop", cnt_drop, 0);
    chk("mrst_lseq", last_seq, 0);
    model_reset();
    send_frame(48'h5555_5555_5555, 16'h1111, 16'h2222, 1, 8'h3F, 1'b1, -1, 1);
    flush();
    compare("mrst");

    // sequence gap detection
    send_frame(MAC, ETYPE, 16'd5, 1, 8'hFF, 1'b1, -1, 1);
    send_frame(MAC, ETYPE, 16'd6, 1, 8'hFF, 1'b1, -1, 1);
    send_frame(MAC, ETYPE, 16'd8, 1, 8'hFF, 1'b1, -1, 1);
    flush();
    chk("t6_gap", cnt_seq_gap, 1);
    chk("t6_lseq", last_seq, 8);
    compare("t6");

    // random traffic
    full_pct = 8;
    gap_pct  = 20;
    rseq = 16'($urandom);
    for (int fr = 0; fr < 400; fr++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       dst = MAC;
      else if (r == 7) dst = BC;
      else             dst = {16'hBEEF, $urandom};
      et = ($urandom_range(0, 99) < 88) ? ETYPE : 16'h0800;
      if ($urandom_range(0, 3) == 0) rseq = 16'($urandom);
      else                           rseq = rseq + 16'd1;
      send_frame(dst, et, rseq, $urandom_range(0, 7) - 1, 8'hFF >> $urandom_range(0, 7),
                 ($urandom_range(0, 99) < 80), -1, 1);
      if (fr % 25 == 24) begin
        flush();
        compare("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
